// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared encodings for the debug clock / single-step logic.
//   - S_HALT..S_FAST : FSM state encodings, also driven out on STATE for LEDs
//   - MODE_*         : switch encodings; identical to the state they select
//   - DEFAULT_DEBOUNCE_CYCLES / DEFAULT_DEBOUNCE_WIDTH : 10 ms at 50 MHz
// -----------------------------------------------------------------------------
package debug_pkg;

    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_SLOW = 2'd2;
    localparam logic [1:0] S_FAST = 2'd3;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEFAULT_DEBOUNCE_WIDTH  = 20;

endpackage

// File: rtl/debug_debouncer.sv
// -----------------------------------------------------------------------------
// debug_debouncer
// Synchronises a raw, bouncing push-button and accepts a new level only after
// the synchronised input has disagreed with the current level for
// DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle restarts the count.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   din_i    raw button input (asynchronous)
//   level_o  debounced level
//   rise_o   one-cycle pulse, registered, when level_o goes 0 -> 1
// -----------------------------------------------------------------------------
module debug_debouncer
    import debug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned DEBOUNCE_WIDTH  = DEFAULT_DEBOUNCE_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [DEBOUNCE_WIDTH-1:0] CntLast = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]                sync_d, sync_q;
    logic [DEBOUNCE_WIDTH-1:0] cnt_d, cnt_q;
    logic                      level_d, level_q;
    logic                      rise_d, rise_q;

    always_comb begin
        sync_d  = {sync_q[0], din_i};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            // cnt_q counts mismatch cycles already seen; this is the last one
            if (cnt_q == CntLast) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/debug_step_controller.sv
// -----------------------------------------------------------------------------
// debug_step_controller
// Generates the processor clock-enable from the divided debug clock and the
// step push-button. Modes: halt, single-step, slow (divided rate), fast.
// Ports:
//   IN_50Mhz     system clock, the only clock
//   RESET        asynchronous active-high reset
//   SLOW_CLK     divided debug clock (square wave, asynchronous to IN_50Mhz)
//   MODE         00 halt, 01 step, 10 slow, 11 fast
//   STEP_BUTTON  raw active-high push-button
//   HALT_REQ     one-cycle halt request from the core
//   CPU_EN       registered clock-enable pulse to the core
//   STEP_COUNT   number of CPU_EN cycles issued, wrapping
//   STATE        current FSM state
//   HALTED       sticky halt flag
// -----------------------------------------------------------------------------
module debug_step_controller
    import debug_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned DEBOUNCE_WIDTH  = DEFAULT_DEBOUNCE_WIDTH,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic                   IN_50Mhz,
    input  logic                   RESET,
    input  logic                   SLOW_CLK,
    input  logic [1:0]             MODE,
    input  logic                   STEP_BUTTON,
    input  logic                   HALT_REQ,
    output logic                   CPU_EN,
    output logic [COUNT_WIDTH-1:0] STEP_COUNT,
    output logic [1:0]             STATE,
    output logic                   HALTED
);

    // [1:0] synchroniser, [2] previous synchronised value for edge detect
    logic [2:0]             slow_sync_d, slow_sync_q;
    logic                   slow_tick;
    logic                   step_tick;
    logic                   unused_step_level;

    logic [1:0]             state_d, state_q;
    logic                   halted_d, halted_q;
    logic                   cpu_en_d, cpu_en_q;
    logic [COUNT_WIDTH-1:0] count_d, count_q;

    debug_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) u_step_debouncer (
        .clk_i  (IN_50Mhz),
        .rst_i  (RESET),
        .din_i  (STEP_BUTTON),
        .level_o(unused_step_level),
        .rise_o (step_tick)
    );

    assign slow_sync_d = {slow_sync_q[1:0], SLOW_CLK};
    assign slow_tick   = slow_sync_q[1] & ~slow_sync_q[2];

    always_comb begin
        // Halt is sticky until the switches are returned to halt
        halted_d = halted_q;
        if (HALT_REQ) begin
            halted_d = 1'b1;
        end else if (MODE == MODE_HALT) begin
            halted_d = 1'b0;
        end

        state_d = (halted_q || HALT_REQ) ? S_HALT : MODE;

        // Ticks arriving in the wrong state are dropped, never queued
        case (state_q)
            S_FAST:  cpu_en_d = 1'b1;
            S_SLOW:  cpu_en_d = slow_tick;
            S_STEP:  cpu_en_d = step_tick;
            default: cpu_en_d = 1'b0;
        endcase
        if (HALT_REQ) begin
            cpu_en_d = 1'b0;
        end

        count_d = count_q;
        if (cpu_en_q) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge IN_50Mhz or posedge RESET) begin
        if (RESET) begin
            slow_sync_q <= '0;
            state_q     <= S_HALT;
            halted_q    <= 1'b0;
            cpu_en_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            slow_sync_q <= slow_sync_d;
            state_q     <= state_d;
            halted_q    <= halted_d;
            cpu_en_q    <= cpu_en_d;
            count_q     <= count_d;
        end
    end

    assign CPU_EN     = cpu_en_q;
    assign STEP_COUNT = count_q;
    assign STATE      = state_q;
    assign HALTED     = halted_q;

endmodule

// File: tb/tb_debug_step_controller.sv
// -----------------------------------------------------------------------------
// tb_debug_step_controller
// Directed bench for debug_step_controller with DEBOUNCE_CYCLES = 8.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_debug_step_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slow_clk = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        button = 1'b0;
    logic        halt_req = 1'b0;
    logic        cpu_en;
    logic [15:0] step_count;
    logic [1:0]  state;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;
    int en_hi = 0;  // running count of CPU_EN-high cycles
    int base;

    debug_step_controller #(
        .DEBOUNCE_CYCLES(8),
        .DEBOUNCE_WIDTH (4),
        .COUNT_WIDTH    (16)
    ) dut (
        .IN_50Mhz   (clk),
        .RESET      (rst),
        .SLOW_CLK   (slow_clk),
        .MODE       (mode),
        .STEP_BUTTON(button),
        .HALT_REQ   (halt_req),
        .CPU_EN     (cpu_en),
        .STEP_COUNT (step_count),
        .STATE      (state),
        .HALTED     (halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_en) en_hi++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset values
        step(2);
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_count", 32'(step_count), 0);
        check("rst_state", 32'(state), 0);
        check("rst_halted", 32'(halted), 0);

        // Fast: MODE=11 held 20 cycles -> 20 enable cycles
        rst  = 1'b0;
        mode = 2'b11;
        base = en_hi;
        step(1);
        check("fast_state", 32'(state), 3);
        check("fast_first_en", 32'(cpu_en), 0);
        step(19);
        mode = 2'b00;
        step(3);
        check("fast_en_cycles", 32'(en_hi - base), 20);
        check("fast_count", 32'(step_count), 20);

        // Slow: period 16, pulse exactly 3 cycles after each rise
        mode = 2'b10;
        step(2);
        check("slow_state", 32'(state), 2);
        base = en_hi;
        for (int p = 0; p < 4; p++) begin
            slow_clk = 1'b1;
            step(2);
            check("slow_pre", 32'(cpu_en), 0);
            step(1);
            check("slow_pulse", 32'(cpu_en), 1);
            step(1);
            check("slow_post", 32'(cpu_en), 0);
            step(4);
            slow_clk = 1'b0;
            step(8);
        end
        check("slow_en_cycles", 32'(en_hi - base), 4);
        mode = 2'b00;
        step(2);
        check("slow_count", 32'(step_count), 24);

        // Step: chatter, then a stable press -> one pulse 11 cycles later
        mode = 2'b01;
        step(2);
        base = en_hi;
        for (int i = 0; i < 5; i++) begin
            button = 1'b1;
            step(3);
            button = 1'b0;
            step(3);
        end
        button = 1'b1;
        step(10);
        check("step_pre", 32'(cpu_en), 0);
        step(1);
        check("step_pulse", 32'(cpu_en), 1);
        step(1);
        check("step_post", 32'(cpu_en), 0);
        step(28);
        button = 1'b0;
        step(20);
        // Press accepted while halted is discarded, not held for later
        mode   = 2'b00;
        button = 1'b1;
        step(20);
        mode = 2'b01;
        step(10);
        button = 1'b0;
        step(20);
        button = 1'b1;
        step(20);
        check("step_en_cycles", 32'(en_hi - base), 2);
        button = 1'b0;
        step(20);
        mode = 2'b00;
        step(2);
        check("step_count", 32'(step_count), 26);

        // Halt request while running fast
        mode = 2'b11;
        step(4);
        check("halt_running", 32'(cpu_en), 1);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        check("halt_en", 32'(cpu_en), 0);
        check("halt_flag", 32'(halted), 1);
        check("halt_state", 32'(state), 0);
        step(3);
        check("halt_sticky_en", 32'(cpu_en), 0);
        check("halt_sticky_state", 32'(state), 0);
        check("halt_sticky_flag", 32'(halted), 1);
        mode = 2'b00;
        step(1);
        check("halt_clear", 32'(halted), 0);
        mode = 2'b11;
        step(2);
        check("halt_resume", 32'(cpu_en), 1);
        mode = 2'b00;
        step(3);
        check("halt_count", 32'(step_count), 31);

        // Halt coincident with slow_tick
        mode = 2'b10;
        step(2);
        slow_clk = 1'b1;
        step(2);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        check("sim_en", 32'(cpu_en), 0);
        check("sim_halted", 32'(halted), 1);
        step(3);
        check("sim_count", 32'(step_count), 31);
        slow_clk = 1'b0;
        mode     = 2'b00;
        step(1);
        check("sim_clear", 32'(halted), 0);

        // Counter wrap from a fresh reset
        rst = 1'b1;
        step(1);
        rst  = 1'b0;
        mode = 2'b11;
        step(65537);
        check("wrap_ffff", 32'(step_count), 32'h0000_ffff);
        mode = 2'b00;
        step(1);
        check("wrap_zero", 32'(step_count), 0);
        step(2);
        check("wrap_one", 32'(step_count), 1);

        // Asynchronous reset mid-run
        mode = 2'b11;
        step(5);
        check("mr_running", 32'(cpu_en), 1);
        #3;
        rst = 1'b1;
        #1;
        check("mr_cpu_en", 32'(cpu_en), 0);
        check("mr_count", 32'(step_count), 0);
        check("mr_state", 32'(state), 0);
        check("mr_halted", 32'(halted), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);
        check("mr_first_en", 32'(cpu_en), 0);
        check("mr_first_state", 32'(state), 3);
        step(1);
        check("mr_second_en", 32'(cpu_en), 1);

        // Asynchronous reset mid-debounce restarts the debounce
        mode = 2'b01;
        step(2);
        button = 1'b1;
        step(6);
        #3;
        rst = 1'b1;
        #1;
        check("md_cpu_en", 32'(cpu_en), 0);
        check("md_state", 32'(state), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(10);
        check("md_pre", 32'(cpu_en), 0);
        step(1);
        check("md_pulse", 32'(cpu_en), 1);
        step(1);
        check("md_post", 32'(cpu_en), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
